// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, default
// reset PC, MIPS instruction field positions, fetch FSM encoding and the
// prefetch buffer entry layout.
package fetch_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Instruction field bit positions
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   // RUN: responses are kept; FLUSH: responses of squashed fetches are dropped
   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   // One prefetch slot: the word and the address it was fetched from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Sequential word address, wrapping from 32'hFFFF_FFFC to 0
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding prefetched {pc, inst} entries. Push and pop
// may happen together, including when full. Clear empties it in one cycle and
// wins over a same-cycle push or pop. Head is read combinationally so a
// buffered word can be loaded into IF/ID at the very next edge.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   fetch_entry_t  slot_reg [DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop && (count_reg != '0) && !clear;
   assign do_push = push && !clear && ((count_reg != CW'(DEPTH)) || do_pop);

   // Entry storage; contents of empty slots are don't-care, so no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         slot_reg[wr_ptr_reg] <= push_entry;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!do_push && do_pop) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign head  = slot_reg[rd_ptr_reg];
   assign count = count_reg;
   assign empty = (count_reg == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order requests to
// instruction memory, buffers returned words and drives the IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN: when defined, a redirect leaves the
// instruction currently in IF/ID in place (delay slot); otherwise a redirect
// squashes IF/ID with a bubble. Buffer and in-flight fetches are flushed in
// both builds.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_id,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic [4:0]  rs_out,
   output logic [4:0]  rt_out,
   output logic [4:0]  rd_out,
   output logic [15:0] imm_out
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int SW = CW + 1;

   fetch_state_t  state_reg;
   fetch_state_t  state_next;
   logic [31:0]   pc_reg;
   logic [31:0]   resp_pc_reg;
   logic [CW-1:0] outstanding_reg;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] drop_count_reg;
   logic          inst_valid_reg;
   logic [31:0]   inst_reg;
   logic [31:0]   id_pc_reg;

   logic [CW-1:0] buf_count;
   logic          buf_empty;
   fetch_entry_t  buf_head;
   fetch_entry_t  push_entry;
   logic [SW-1:0] occupancy;
   logic          accept;
   logic          in_flush;
   logic          keep;
   logic          bypass;
   logic          buf_push;
   logic          buf_pop;

   // Fetches are throttled so that in-flight plus buffered words fit the buffer
   assign occupancy = SW'(outstanding_reg) + SW'(buf_count);
   assign imem_req  = !reset && (occupancy < SW'(BUF_DEPTH));
   assign imem_addr = pc_reg;
   assign accept    = imem_req && imem_ready;

   // Outstanding count after this edge: +1 per accept, -1 per response
   always_comb begin
      outstanding_next = outstanding_reg;
      if (accept && !imem_rvalid) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!accept && imem_rvalid) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state: enter FLUSH while stale fetches are still in flight
   always_comb begin
      state_next = state_reg;
      if (redirect_valid) begin
         state_next = (outstanding_next != '0) ? FLUSH : RUN;
      end else if ((state_reg == FLUSH) && imem_rvalid && (drop_count_reg == CW'(1))) begin
         state_next = RUN;
      end
   end

   // FSM outputs: responses arriving in FLUSH belong to squashed fetches
   always_comb begin
      in_flush = (state_reg == FLUSH);
   end

   // A response is kept unless it is stale or arrives with a redirect
   assign keep     = imem_rvalid && !in_flush && !redirect_valid;
   assign bypass   = keep && buf_empty && !stall_id;
   assign buf_push = keep && !bypass;
   assign buf_pop  = !stall_id && !buf_empty && !redirect_valid;

   assign push_entry = '{pc: resp_pc_reg, inst: imem_rdata};

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .clear      (redirect_valid),
      .push       (buf_push),
      .push_entry (push_entry),
      .pop        (buf_pop),
      .head       (buf_head),
      .count      (buf_count),
      .empty      (buf_empty)
   );

   // In-flight and stale-response counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding_reg <= '0;
         drop_count_reg  <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (redirect_valid) begin
            drop_count_reg <= outstanding_next;
         end else if (in_flush && imem_rvalid) begin
            drop_count_reg <= drop_count_reg - 1'b1;
         end
      end
   end

   // Program counter: redirect beats the sequential advance of an accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg <= RESET_PC;
      end else if (redirect_valid) begin
         pc_reg <= redirect_pc;
      end else if (accept) begin
         pc_reg <= next_pc(pc_reg);
      end
   end

   // Address of the next kept response; kept words are always sequential
   // from the last redirect target, so a single running address suffices
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_pc_reg <= RESET_PC;
      end else if (redirect_valid) begin
         resp_pc_reg <= redirect_pc;
      end else if (keep) begin
         resp_pc_reg <= next_pc(resp_pc_reg);
      end
   end

   // IF/ID register: load buffer head, else bypassed word, else a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_valid_reg <= 1'b0;
         inst_reg       <= NOP;
         id_pc_reg      <= '0;
      end else if (redirect_valid) begin
`ifdef BRANCH_DELAY_SLOT_EN
         // The delay-slot instruction already in IF/ID stays valid
         inst_valid_reg <= inst_valid_reg;
`else
         inst_valid_reg <= 1'b0;
         inst_reg       <= NOP;
`endif
      end else if (!stall_id) begin
         if (!buf_empty) begin
            inst_valid_reg <= 1'b1;
            inst_reg       <= buf_head.inst;
            id_pc_reg      <= buf_head.pc;
         end else if (bypass) begin
            inst_valid_reg <= 1'b1;
            inst_reg       <= imem_rdata;
            id_pc_reg      <= resp_pc_reg;
         end else begin
            inst_valid_reg <= 1'b0;
            inst_reg       <= NOP;
         end
      end
   end

   assign inst_valid   = inst_valid_reg;
   assign inst_out     = inst_reg;
   assign pc_out       = id_pc_reg;
   assign pc_plus4_out = next_pc(id_pc_reg);
   assign rs_out       = inst_reg[RS_MSB:RS_LSB];
   assign rt_out       = inst_reg[RT_MSB:RT_LSB];
   assign rd_out       = inst_reg[RD_MSB:RD_LSB];
   assign imm_out      = inst_reg[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a latency-configurable in-order memory,
// a reference stream of expected PCs (sequential from reset or the last
// redirect target), and a monitor that compares every IF/ID load against it.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic [4:0]  rs_out;
   logic [4:0]  rt_out;
   logic [4:0]  rd_out;
   logic [15:0] imm_out;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall_id       (stall_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .pc_plus4_out   (pc_plus4_out),
      .rs_out         (rs_out),
      .rt_out         (rt_out),
      .rd_out         (rd_out),
      .imm_out        (imm_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t mq[$];
   int   lat        = 1;
   int   ready_mode = 0;   // 0 always ready, 1 alternate, 2 random
   int   edge_cnt   = 0;
   int   inflight   = 0;
   bit   word_mode  = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (!word_mode) return a;
      return a ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   initial begin
      bit          acc;
      logic [31:0] acc_addr;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         acc      = imem_req && imem_ready && !reset;
         acc_addr = imem_addr;
         @(posedge clk);
         edge_cnt++;
         if (reset) begin
            mq.delete();
            inflight = 0;
         end else begin
            if (imem_rvalid) inflight--;
            if (acc) begin
               mq.push_back('{addr: acc_addr, due: edge_cnt + lat - 1});
               inflight++;
            end
         end
         #1;
         case (ready_mode)
            1:       imem_ready = !imem_ready;
            2:       imem_ready = ($urandom_range(0, 3) != 0);
            default: imem_ready = 1'b1;
         endcase
         if (!reset && (mq.size() > 0) && (mq[0].due <= edge_cnt)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [31:0] exp_q[$];
   logic [31:0] stream_pc;
   bit          prev_stall;
   bit          prev_redir;
   logic [31:0] prev_target;
   logic        mdl_valid;
   logic [31:0] mdl_inst;
   logic [31:0] mdl_pc;
   logic [31:0] last_pc;
   int          loads     = 0;
   bit          wrap_seen = 1'b0;

   initial begin
      logic [31:0] e;
      logic [31:0] w;
      stream_pc  = RESET_PC;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      prev_target = '0;
      mdl_valid  = 1'b0;
      mdl_inst   = '0;
      mdl_pc     = '0;
      last_pc    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            stream_pc = RESET_PC;
            mdl_valid = 1'b0;
            mdl_inst  = '0;
            mdl_pc    = '0;
         end else begin
            check("inflight_le_depth", 32'(inflight <= BUF_DEPTH), 32'd1);
            if (prev_redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
               check("ds_hold_valid", 32'(inst_valid), 32'(mdl_valid));
               check("ds_hold_pc", pc_out, mdl_pc);
`else
               check("redirect_bubble_valid", 32'(inst_valid), 32'd0);
               check("redirect_bubble_nop", inst_out, 32'd0);
               mdl_valid = 1'b0;
               mdl_inst  = '0;
`endif
               exp_q.delete();
               stream_pc = prev_target;
            end else if (prev_stall) begin
               check("stall_hold_valid", 32'(inst_valid), 32'(mdl_valid));
               check("stall_hold_inst", inst_out, mdl_inst);
               if (mdl_valid) check("stall_hold_pc", pc_out, mdl_pc);
            end else if (inst_valid) begin
               while (exp_q.size() < 4) begin
                  exp_q.push_back(stream_pc);
                  stream_pc = stream_pc + 32'd4;
               end
               e = exp_q.pop_front();
               w = mem_word(e);
               check("pc_out", pc_out, e);
               check("inst_out", inst_out, w);
               check("pc_plus4", pc_plus4_out, e + 32'd4);
               check("rs", 32'(rs_out), 32'(w[25:21]));
               check("rt", 32'(rt_out), 32'(w[20:16]));
               check("rd", 32'(rd_out), 32'(w[15:11]));
               check("imm", 32'(imm_out), 32'(w[15:0]));
               if ((loads > 0) && (last_pc == 32'hFFFF_FFFC) && (e == 32'h0)) wrap_seen = 1'b1;
               last_pc   = e;
               loads++;
               mdl_valid = 1'b1;
               mdl_inst  = w;
               mdl_pc    = e;
            end else begin
               check("bubble_nop", inst_out, 32'd0);
               mdl_valid = 1'b0;
               mdl_inst  = '0;
            end
         end
         prev_stall  = stall_id;
         prev_redir  = redirect_valid;
         prev_target = redirect_pc;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_values();
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_out", inst_out, 32'd0);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_pc_plus4", pc_plus4_out, 32'd4);
      check("rst_fields", {rs_out, rt_out, rd_out, imm_out[14:0]}, 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   bit found;
   int loads_before;

   initial begin
      reset          = 1'b1;
      stall_id       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1 reset = 1'b0;

      // First request and first valid instruction timing
      @(negedge clk);
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, RESET_PC);
      @(negedge clk);
      check("edge1_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
      check("edge2_valid", 32'(inst_valid), 32'd1);
      check("edge2_pc", pc_out, RESET_PC);

      // Stall three cycles while pc_out = 8
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (inst_valid && (pc_out == 32'h8)) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_pc8", 32'(found), 32'd1);
      stall_id = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("stall_req_low", 32'(imem_req), 32'd0);
      check("stall_pc_hold", pc_out, 32'h8);
      @(posedge clk);
      #1 stall_id = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release_pc12", pc_out, 32'hC);
      check("release_valid12", 32'(inst_valid), 32'd1);
      @(negedge clk);
      check("release_pc16", pc_out, 32'h10);
      check("release_valid16", 32'(inst_valid), 32'd1);

      // Redirect to 0x100 with one fetch in flight
      repeat (3) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      @(negedge clk);
`ifdef BRANCH_DELAY_SLOT_EN
      check("redir_ds_valid", 32'(inst_valid), 32'd1);
`else
      check("redir_bubble", 32'(inst_valid), 32'd0);
`endif
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("redir_target_pc", pc_out, 32'h100);
      check("redir_target_valid", 32'(inst_valid), 32'd1);

      // Alternating ready with latency 3
      @(posedge clk);
      #1;
      lat        = 3;
      ready_mode = 1;
      loads_before = loads;
      repeat (60) @(posedge clk);
      #1;
      ready_mode = 0;
      check("slow_mem_progress", 32'(loads - loads_before > 10), 32'd1);
      repeat (4) @(posedge clk);
      #1 lat = 1;
      repeat (4) @(posedge clk);

      // Redirect to the top of the address space: PC wraps to 0
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("wrap_seen", 32'(wrap_seen), 32'd1);

      // Reset asserted while flushing
      lat = 3;
      repeat (6) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      reset          = 1'b1;
      @(negedge clk);
      check_reset_values();
      word_mode = 1'b1;
      lat       = 1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("restart_req", 32'(imem_req), 32'd1);
      check("restart_addr", imem_addr, RESET_PC);

      // Randomized stall / redirect / ready / latency
      loads_before = loads;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk);
         #1;
         if ((c % 50) == 0) lat = $urandom_range(1, 3);
         ready_mode = 2;
         stall_id   = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         end else begin
            redirect_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      stall_id       = 1'b0;
      redirect_valid = 1'b0;
      ready_mode     = 0;
      repeat (10) @(posedge clk);
      #1;
      check("random_progress", 32'(loads - loads_before > 100), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
